// File: rtl/qysys_switch_poll_master_pkg.sv
// qysys_poll_pkg: FSM encoding and counter sizing shared by the switch poll master
package qysys_poll_pkg;
    typedef enum logic [1:0] {IDLE, READ, LAT, CAPTURE} state_t;
    function automatic int cnt_w(int n);
        return n < 2 ? 1 : $clog2(n);
    endfunction
    localparam int DEF_POLL_PERIOD = 50000;
    localparam int POLL_CNT_W = cnt_w(DEF_POLL_PERIOD);
endpackage

// File: rtl/qysys_switch_poll_master_if.sv
// qysys_switch_poll_master_if: Avalon-MM read-only bus between poll master and PIO slave
interface qysys_switch_poll_master_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    modport master(output avm_address, avm_read, input avm_waitrequest, avm_readdata);
    modport slave(input avm_address, avm_read, output avm_waitrequest, avm_readdata);
endinterface

// File: rtl/qysys_switch_poll_master_timer.sv
// qysys_poll_timer: wrapping interval counter, tc_o flags the last count N-1
module qysys_poll_timer
    import qysys_poll_pkg::*;
#(
    parameter int N = 4,
    parameter int W = cnt_w(N)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o  = cnt_q == W'(N - 1);
    assign cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/qysys_switch_poll_master.sv
// qysys_switch_poll_master: periodic Avalon-MM reader of a PIO register with
// change detection and a waitrequest watchdog
module qysys_switch_poll_master
    import qysys_poll_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int POLL_PERIOD  = 50000,
    parameter int READ_LATENCY = 1,
    parameter int REG_ADDR     = 0,
    parameter int TIMEOUT      = 255
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    qysys_switch_poll_master_if.master     avm,
    output logic [DATA_W-1:0]              sample,
    output logic                           sample_valid,
    output logic [DATA_W-1:0]              changed_mask,
    output logic                           change_pulse,
    output logic                           timeout_err,
    output logic                           busy
);
    state_t              state_q;
    logic [1:0]          lat_q;
    logic [DATA_W-1:0]   data_q;
    logic                have_prev_q;
    logic                poll_tc, wait_tc, polling, unused_hi;

    assign polling          = state_q == IDLE && enable;
    assign avm.avm_address  = 2'(REG_ADDR);
    assign avm.avm_read     = state_q == READ;
    assign busy             = state_q != IDLE;
    assign unused_hi        = ^avm.avm_readdata[31:DATA_W];

    qysys_poll_timer #(.N(POLL_PERIOD)) u_poll (
        .clk(clk), .reset_n(reset_n), .en_i(polling), .clr_i(!polling), .tc_o(poll_tc)
    );
    // Counts stalled read cycles only; cleared whenever no read is pending
    qysys_poll_timer #(.N(TIMEOUT)) u_wait (
        .clk(clk), .reset_n(reset_n), .en_i(avm.avm_read && avm.avm_waitrequest),
        .clr_i(!avm.avm_read), .tc_o(wait_tc)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            lat_q        <= '0;
            data_q       <= '0;
            have_prev_q  <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            changed_mask <= '0;
            change_pulse <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            change_pulse <= 1'b0;
            timeout_err  <= 1'b0;
            case (state_q)
                IDLE: if (polling && poll_tc) state_q <= READ;
                READ: begin
                    if (!avm.avm_waitrequest) begin
                        lat_q <= '0;
                        if (READ_LATENCY == 0) begin
                            data_q  <= avm.avm_readdata[DATA_W-1:0];
                            state_q <= CAPTURE;
                        end else state_q <= LAT;
                    end else if (wait_tc) begin
                        timeout_err <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                LAT: begin
                    if (lat_q == 2'(READ_LATENCY - 1)) begin
                        data_q  <= avm.avm_readdata[DATA_W-1:0];
                        state_q <= CAPTURE;
                    end else lat_q <= lat_q + 2'd1;
                end
                CAPTURE: begin
                    sample       <= data_q;
                    sample_valid <= 1'b1;
                    changed_mask <= have_prev_q ? data_q ^ sample : '0;
                    change_pulse <= have_prev_q && data_q != sample;
                    have_prev_q  <= 1'b1;
                    state_q      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qysys_switch_poll_master.sv
// tb_qysys_switch_poll_master: directed stimulus with a capture scoreboard
// and a timeout-pulse monitor
module tb_qysys_switch_poll_master;
    typedef struct packed {
        logic [7:0] s;
        logic [7:0] m;
        logic       c;
    } exp_t;

    logic       clk = 0, reset_n = 0, enable = 0, stuck = 0;
    logic [7:0] in_port = 8'h5A;
    int         stall_n = 0, stall_seen = 0, to_exp = 0;
    int         errors = 0, checks = 0;
    exp_t       q[$];
    logic [7:0] sample, changed_mask;
    logic       sample_valid, change_pulse, timeout_err, busy;

    qysys_switch_poll_master_if bus();

    qysys_switch_poll_master #(.POLL_PERIOD(4), .READ_LATENCY(1), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .avm(bus),
        .sample(sample), .sample_valid(sample_valid), .changed_mask(changed_mask),
        .change_pulse(change_pulse), .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Slave model: upper readdata bits carry junk that must be ignored
    assign bus.avm_readdata    = {24'hA5C3E1, in_port};
    assign bus.avm_waitrequest = stuck | (bus.avm_read && stall_seen < stall_n);

    always @(posedge clk)
        if (!bus.avm_read) stall_seen <= 0;
        else if (bus.avm_waitrequest) stall_seen <= stall_seen + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sample_valid) begin
            if (q.size() == 0) chk("unexpected_capture", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("sample", {24'h0, sample}, {24'h0, e.s});
                chk("changed_mask", {24'h0, changed_mask}, {24'h0, e.m});
                chk("change_pulse", {31'h0, change_pulse}, {31'h0, e.c});
            end
        end else if (change_pulse) chk("change_pulse_without_capture", 1, 0);
        if (timeout_err) begin
            chk("timeout_err_expected", {31'h0, to_exp > 0}, 1);
            to_exp--;
        end
    end

    task automatic wait_rise(output int g);
        g = 0;
        while (!bus.avm_read && g < 100) begin
            @(posedge clk); #1; g++;
        end
    endtask

    task automatic wait_fall(output int l);
        l = 0;
        while (bus.avm_read && l < 100) begin
            @(posedge clk); #1; l++;
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("capture_pending", q.size(), 0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_sample"}, {24'h0, sample}, 0);
        chk({tag, "_mask"}, {24'h0, changed_mask}, 0);
        chk({tag, "_flags"}, {27'h0, sample_valid, change_pulse, timeout_err, busy, bus.avm_read}, 0);
    endtask

    initial begin
        int g, l, reads;
        repeat (3) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        chk("reset_address", {30'h0, bus.avm_address}, 0);
        @(negedge clk) reset_n = 1;
        @(posedge clk); #1;
        // 1: first poll and capture, no change pulse on first sample
        q.push_back('{8'h5A, 8'h00, 1'b0});
        enable = 1;
        wait_rise(g); chk("first_gap", g, 4);
        wait_fall(l); chk("read_len_nowait", l, 1);
        wait_done();
        // 2: single-bit change, then a steady poll
        in_port = 8'h5B;
        q.push_back('{8'h5B, 8'h01, 1'b1});
        wait_rise(g); wait_fall(l); wait_done();
        q.push_back('{8'h5B, 8'h00, 1'b0});
        wait_rise(g); wait_fall(l); wait_done();
        // 3: three stall cycles
        stall_n = 3; in_port = 8'h3C;
        q.push_back('{8'h3C, 8'h67, 1'b1});
        wait_rise(g); wait_fall(l); chk("read_len_stall3", l, 4);
        wait_done();
        chk("no_timeout_stall3", to_exp, 0);
        stall_n = 0;
        // 4: stuck waitrequest triggers the watchdog
        stuck = 1; to_exp = 1;
        wait_rise(g); wait_fall(l); chk("read_len_timeout", l, 8);
        stuck = 0;
        chk("sample_after_timeout", {24'h0, sample}, 32'h3C);
        q.push_back('{8'h3C, 8'h00, 1'b0});
        wait_rise(g); chk("gap_after_timeout", g, 4);
        chk("timeout_seen", to_exp, 0);
        wait_fall(l); wait_done();
        // 5: enable drops mid-read
        stall_n = 2; in_port = 8'h81;
        q.push_back('{8'h81, 8'hBD, 1'b1});
        wait_rise(g);
        enable = 0;
        wait_fall(l); chk("read_len_stall2", l, 3);
        wait_done();
        stall_n = 0;
        reads = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.avm_read) reads++;
        end
        chk("reads_while_disabled", reads, 0);
        chk("busy_while_disabled", {31'h0, busy}, 0);
        q.push_back('{8'h81, 8'h00, 1'b0});
        enable = 1;
        wait_rise(g); chk("gap_after_reenable", g, 4);
        wait_fall(l); wait_done();
        // 6: reset during LAT clears everything including history
        in_port = 8'hFF;
        wait_rise(g); wait_fall(l);
        chk("in_lat_busy", {31'h0, busy}, 1);
        reset_n = 0;
        #1;
        chk_zero_outputs("async_reset");
        @(negedge clk) reset_n = 1;
        q.push_back('{8'hFF, 8'h00, 1'b0});
        wait_rise(g); chk("gap_after_reset", g, 4);
        wait_fall(l); wait_done();
        repeat (3) @(posedge clk);
        chk("leftover_timeouts", to_exp, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
